// File: rtl/dtree_vote_accum_if.sv
// dtree_vote_accum_if: prediction input and decision output handshakes of the vote accumulator
interface dtree_vote_accum_if #(parameter int CNT_W = 4);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_class;
  logic out_valid;
  logic out_ready;
  logic [3:0] out_class;
  logic [CNT_W-1:0] out_votes;
  logic out_tie;
  logic [CNT_W-1:0] out_invalid;
  modport master (
    output in_valid, in_class, out_ready,
    input in_ready, out_valid, out_class, out_votes, out_tie, out_invalid
  );
  modport slave (
    input in_valid, in_class, out_ready,
    output in_ready, out_valid, out_class, out_votes, out_tie, out_invalid
  );
endinterface

// File: rtl/dtree_vote_accum.sv
// dtree_vote_accum: tallies a window of tree predictions per class and emits the majority class
module dtree_vote_accum #(
  parameter int NCLASS = 10,
  parameter int WINDOW = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  dtree_vote_accum_if.slave bus
);
  if (WINDOW < 1 || WINDOW > 2 ** CNT_W - 1) begin : g_bad_window
    $error("WINDOW must be in 1..2**CNT_W-1");
  end
  if (NCLASS < 2 || NCLASS > 15) begin : g_bad_nclass
    $error("NCLASS must be in 2..15");
  end
  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] vote [NCLASS];
  logic [CNT_W-1:0] sample, invalid, cur, best_votes, nx_votes;
  logic [3:0] idx, best_class, nx_class;
  logic best_tie, nx_tie, accept, last_in, last_idx, gt, eq, take;
  assign accept = state == ACCUM && bus.in_valid;
  assign take = state == HOLD && bus.out_ready;
  assign last_in = sample == CNT_W'(WINDOW - 1);
  assign last_idx = idx == 4'(NCLASS - 1);
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == HOLD;
  always_comb begin
    cur = '0;
    for (int k = 0; k < NCLASS; k++) cur = idx == 4'(k) ? vote[k] : cur;
    gt = cur > best_votes;
    eq = cur == best_votes && best_votes != '0;
    nx_class = gt ? idx : best_class;
    nx_votes = gt ? cur : best_votes;
    nx_tie = gt ? 1'b0 : (eq | best_tie);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == ACCUM ? (accept && last_in ? SCAN : ACCUM)
             : state == SCAN ? (last_idx ? HOLD : SCAN)
             : (bus.out_ready ? ACCUM : HOLD);
  end
  always_ff @(posedge clk) state <= !rst_n ? ACCUM : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n || take) begin
      for (int k = 0; k < NCLASS; k++) vote[k] <= '0;
      sample <= '0;
      invalid <= '0;
    end else if (accept) begin
      for (int k = 0; k < NCLASS; k++)
        if (bus.in_class == 4'(k)) vote[k] <= vote[k] + CNT_W'(1);
      invalid <= invalid + CNT_W'(bus.in_class >= 4'(NCLASS));
      sample <= last_in ? '0 : sample + CNT_W'(1);
    end
  end
  // the running best restarts on every accept so SCAN always begins from (F,0,0)
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      idx <= '0;
      best_class <= 4'hF;
      best_votes <= '0;
      best_tie <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx + 4'd1;
      best_class <= nx_class;
      best_votes <= nx_votes;
      best_tie <= nx_tie;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_class <= 4'hF;
      bus.out_votes <= '0;
      bus.out_tie <= 1'b0;
      bus.out_invalid <= '0;
    end else if (state == SCAN && last_idx) begin
      bus.out_class <= nx_class;
      bus.out_votes <= nx_votes;
      bus.out_tie <= nx_tie;
      bus.out_invalid <= invalid;
    end
  end
endmodule

// File: tb/tb_dtree_vote_accum.sv
// tb_dtree_vote_accum: randomized and directed checks of the vote accumulator against a counting model
module tb_dtree_vote_accum;
  localparam int NC = 10;
  localparam int W = 8;
  logic clk = 0;
  logic rst_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  dtree_vote_accum_if #(.CNT_W(4)) bus ();
  dtree_vote_accum #(.NCLASS(NC), .WINDOW(W), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [13:0] model(input int q[$]);
    int cnt[16];
    int c, v, inv;
    logic t;
    c = 15;
    v = 0;
    inv = 0;
    t = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (q[i]) if (q[i] < NC) cnt[q[i]]++; else inv++;
    for (int k = 0; k < NC; k++) if (cnt[k] > v) begin v = cnt[k]; c = k; end
    for (int k = 0; k < NC; k++) if (k != c && v > 0 && cnt[k] == v) t = 1'b1;
    return {1'b1, 4'(c), 4'(v), t, 4'(inv)};
  endfunction
  function automatic logic [13:0] got();
    return {bus.out_valid, bus.out_class, bus.out_votes, bus.out_tie, bus.out_invalid};
  endfunction
  task automatic send(input int q[$], input int gap);
    foreach (q[i]) begin
      if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))) begin
        bus.in_valid = 0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1;
      bus.in_class = 4'(q[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
  endtask
  task automatic wait_valid(output int n, input bit pulse);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      bus.in_valid = pulse && (n % 2 == 1);
      bus.in_class = 4'd0;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 0;
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.in_ready, got()} !== {1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset: got %h required %h", {bus.in_ready, got()}, {1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0});
    end
  endtask
  task automatic test_majority();
    int q[$] = '{3, 3, 7, 3, 1, 3, 7, 3};
    int n;
    logic [13:0] exp, hold;
    exp = model(q);
    bus.out_ready = 1;
    send(q, 0);
    wait_valid(n, 0);
    n_cmp++;
    if (n + 1 !== NC + 1) begin n_bad++; $display("FAIL latency: got %0d required %0d", n + 1, NC + 1); end
    n_cmp++;
    if (got() !== exp) begin n_bad++; $display("FAIL majority: got %h required %h", got(), exp); end
    hold = got();
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL after_take: in_ready/out_valid got %b required 10", {bus.in_ready, bus.out_valid});
    end
    n_cmp++;
    if (got()[12:0] !== hold[12:0]) begin n_bad++; $display("FAIL keep_fields: got %h required %h", got()[12:0], hold[12:0]); end
  endtask
  task automatic test_tie();
    int q[$] = '{5, 2, 5, 2, 5, 2, 9, 9};
    int n;
    send(q, 0);
    wait_valid(n, 0);
    n_cmp++;
    if (got() !== model(q)) begin n_bad++; $display("FAIL tie: got %h required %h", got(), model(q)); end
    @(posedge clk); #1;
  endtask
  task automatic test_illegal();
    int q[$] = '{12, 12, 4, 15, 4, 0, 12, 13};
    int n;
    bit stable = 1;
    logic [13:0] first;
    bus.out_ready = 0;
    send(q, 0);
    wait_valid(n, 1);
    n_cmp++;
    if (got() !== model(q)) begin n_bad++; $display("FAIL illegal: got %h required %h", got(), model(q)); end
    first = got();
    repeat (5) begin
      bus.in_valid = 1;
      bus.in_class = 4'd4;
      @(posedge clk); #1;
      if (got() !== first || bus.in_ready !== 1'b0) stable = 0;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL stall_stable: got %h required %h", got(), first); end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    q = '{14, 14, 14, 14, 14, 14, 14, 14};
    send(q, 0);
    wait_valid(n, 0);
    n_cmp++;
    if (got() !== {1'b1, 4'hF, 4'h0, 1'b0, 4'h8}) begin
      n_bad++;
      $display("FAIL all_illegal: got %h required %h", got(), {1'b1, 4'hF, 4'h0, 1'b0, 4'h8});
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    int q[$] = '{1, 1, 1, 1, 1, 1};
    int n;
    bit quiet = 1;
    bus.out_ready = 1;
    send(q, 0);
    pulse_reset();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_accum: in_ready/out_valid got %b required 10", {bus.in_ready, bus.out_valid});
    end
    q = '{6, 6, 6, 6, 6, 6, 6, 6};
    send(q, 0);
    wait_valid(n, 0);
    n_cmp++;
    if (got() !== {1'b1, 4'd6, 4'd8, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_recover: got %h required %h", got(), {1'b1, 4'd6, 4'd8, 1'b0, 4'd0});
    end
    @(posedge clk); #1;
    q = '{2, 3, 3, 8, 2, 3, 0, 11};
    send(q, 0);
    repeat (4) @(posedge clk);
    #1 pulse_reset();
    repeat (15) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) quiet = 0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL reset_scan: out_valid got %b required 0", bus.out_valid); end
    bus.out_ready = 0;
    send(q, 0);
    wait_valid(n, 0);
    pulse_reset();
    n_cmp++;
    if (got() !== {1'b0, 4'hF, 4'h0, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_hold: got %h required %h", got(), {1'b0, 4'hF, 4'h0, 1'b0, 4'h0});
    end
    bus.out_ready = 1;
  endtask
  task automatic test_gapped();
    int q[$] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int n;
    send(q, 1);
    wait_valid(n, 0);
    n_cmp++;
    if (got() !== {1'b1, 4'd0, 4'd8, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL gapped: got %h required %h", got(), {1'b1, 4'd0, 4'd8, 1'b0, 4'd0});
    end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    int q[$];
    int n, stall;
    for (int w = 0; w < 20; w++) begin
      q.delete();
      for (int i = 0; i < W; i++) q.push_back($urandom_range(0, 12) == 12 ? 15 : $urandom_range(0, 10));
      stall = $urandom_range(0, 3);
      bus.out_ready = stall == 0;
      send(q, 2);
      wait_valid(n, 1);
      n_cmp++;
      if (got() !== model(q)) begin n_bad++; $display("FAIL random_%0d: got %h required %h", w, got(), model(q)); end
      repeat (stall) @(posedge clk);
      #1 bus.out_ready = 1;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_class = 0;
    bus.out_ready = 0;
    test_reset();
    test_majority();
    test_tie();
    test_illegal();
    test_reset_mid();
    test_gapped();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
